// File: rtl/ram.sv
// Single-port synchronous RAM with a shared address bus and a registered,
// read-before-write output port. Contents power up to zero and survive reset.
module ram #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  input  logic              rden,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 1 << ADDR_W;

  // Zero power-up image; reset never touches the array, only the output register.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (rden) q_d = mem_q[address];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Non-blocking update keeps the same-edge read returning the old word.
  always_ff @(posedge clk) begin
    if (rst_n && wren) begin
      mem_q[address] <= data;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed test-plan sequences followed by
// randomized traffic compared against an array-based reference model.
module tb_ram;

  localparam int DATA_W = 14;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              rden;
  logic [DATA_W-1:0] q;

  ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .data    (data),
    .wren    (wren),
    .rden    (rden),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] model_q;
  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: q=%h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge of traffic; the model applies the read before the write.
  task automatic step(input logic rst, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic we, input logic re,
                      input string tag);
    rst_n   = ~rst;
    address = a;
    data    = d;
    wren    = we;
    rden    = re;
    @(posedge clk);
    if (rst) begin
      model_q = '0;
    end else begin
      if (re) model_q = model_mem[a];
      if (we) model_mem[a] = d;
    end
    @(negedge clk);
    check(tag, q, model_q);
  endtask

  logic [DATA_W-1:0] held;

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_q = '0;
    rst_n = 1'b0; address = '0; data = '0; wren = 1'b0; rden = 1'b0;
    @(negedge clk);

    step(1'b1, 12'd0, 14'd0, 1'b0, 1'b0, "reset");
    check("reset_const", q, 14'd0);

    step(1'b0, 12'd4, 14'd0, 1'b0, 1'b1, "pwrup_rd");
    check("pwrup_rd_const", q, 14'd0);
    step(1'b0, 12'd0, 14'd0, 1'b0, 1'b0, "pwrup_hold");
    check("pwrup_hold_const", q, 14'd0);

    step(1'b0, 12'd4, 14'd3, 1'b1, 1'b0, "wr4");
    step(1'b0, 12'd0, 14'd0, 1'b0, 1'b0, "gap_hold");
    check("gap_hold_const", q, 14'd0);
    step(1'b0, 12'd4, 14'd0, 1'b0, 1'b1, "rd4");
    check("rd4_const", q, 14'd3);

    step(1'b0, 12'd7, 14'h155, 1'b1, 1'b0, "preload7");
    step(1'b0, 12'd7, 14'h2AA, 1'b1, 1'b1, "rbw");
    check("rbw_old", q, 14'h155);
    step(1'b0, 12'd7, 14'd0, 1'b0, 1'b1, "rd7");
    check("rd7_new", q, 14'h2AA);

    step(1'b0, 12'd4, 14'd0, 1'b0, 1'b1, "rd4_pre_rst");
    check("rd4_pre_rst_const", q, 14'd3);
    step(1'b1, 12'd4, 14'd9, 1'b1, 1'b1, "rst_wr");
    check("rst_wr_const", q, 14'd0);
    step(1'b0, 12'd4, 14'd0, 1'b0, 1'b1, "rd4_post_rst");
    check("rd4_post_rst_const", q, 14'd3);

    step(1'b0, 12'd0,    14'h3FFF, 1'b1, 1'b0, "wr_lo");
    step(1'b0, 12'd4095, 14'h0001, 1'b1, 1'b0, "wr_hi");
    step(1'b0, 12'd0,    14'd0,    1'b0, 1'b1, "rd_lo");
    check("rd_lo_const", q, 14'h3FFF);
    step(1'b0, 12'd4095, 14'd0,    1'b0, 1'b1, "rd_hi");
    check("rd_hi_const", q, 14'h0001);

    step(1'b0, 12'd7, 14'd0, 1'b0, 1'b1, "hold_rd");
    held = model_q;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, ADDR_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0, "hold");
      check("hold_const", q, held);
    end

    // Random traffic; half the addresses land in a small window to force reuse.
    for (int i = 0; i < 3000; i++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 15))
                                      : ADDR_W'($urandom);
      step(($urandom_range(0, 31) == 0), a, DATA_W'($urandom),
           1'($urandom), 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
